// File: rtl/sysmem_responder_if.sv
// ---------------------------------------------------------------------------
// sysmem_responder_if
// Request/response bundle for the CPU-side memory bus (IM/DM/IOM style).
//   mem_read     master -> slave   request is a read
//   mem_write    master -> slave   request is a write (wins over mem_read)
//   mem_enable   master -> slave   request strobe
//   mem_address  master -> slave   byte address, bits [1:0] ignored
//   mem_in       master -> slave   write data
//   mem_out      slave  -> master  read data, held until the next read completes
//   mem_ready    slave  -> master  1 = a request may be presented
//   mem_done     slave  -> master  one-cycle completion pulse
//   mem_error    slave  -> master  one-cycle pulse with mem_done on out-of-range access
// ---------------------------------------------------------------------------
interface sysmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic        mem_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        mem_ready;
    logic        mem_done;
    logic        mem_error;

    // The CPU (or cache Sys* port) drives requests.
    modport master (
        output mem_read, mem_write, mem_enable, mem_address, mem_in,
        input  mem_out, mem_ready, mem_done, mem_error
    );

    // The memory responder answers them.
    modport slave (
        input  mem_read, mem_write, mem_enable, mem_address, mem_in,
        output mem_out, mem_ready, mem_done, mem_error
    );
endinterface

// File: rtl/sysmem_responder.sv
// ---------------------------------------------------------------------------
// sysmem_responder
// Memory-side responder holding a word-addressed 32-bit RAM. Each accepted
// request is answered after LATENCY wait states, followed by a single DONE
// cycle. Only values latched at acceptance are used while busy.
//   clock   in   single clock, rising edge
//   reset   in   asynchronous, active-high
//   bus     slave modport of sysmem_responder_if (request in, response out)
// Parameters:
//   ADDR_W  word-address bits, RAM depth 2**ADDR_W words
//   LATENCY wait-state cycles per access, 1..15
// ---------------------------------------------------------------------------
module sysmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic          clock,
    input  logic          reset,
    sysmem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [31:0]       ram [2**ADDR_W];

    state_t            state;
    logic [3:0]        cnt;
    logic              op_write;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       wdata;
    logic              out_of_range;

    logic [31:0]       out_q;
    logic              ready_q;
    logic              done_q;
    logic              error_q;

    logic              addr_oor;
    logic              ram_we;
    logic              unused_read;

    // Any set bit above the word index means the address lies beyond the RAM.
    assign addr_oor = (bus.mem_address >> (ADDR_W + 2)) != 32'd0;

    // mem_read carries no information of its own: write wins when both are
    // set, and a strobe with neither set is a read.
    assign unused_read = bus.mem_read;

    // The RAM write fires on the last busy edge. It is gated by state, so an
    // asynchronous reset during BUSY drops the pending write.
    assign ram_we = (state == BUSY) && (cnt == 4'd0) && op_write && !out_of_range;

    // RAM array kept outside the reset domain so its contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[idx] <= wdata;
        end
    end

    // Control FSM: latches the request in IDLE, counts wait states in BUSY,
    // performs the read and raises the completion pulses on the transition
    // into DONE, and always spends exactly one cycle in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            op_write     <= 1'b0;
            idx          <= '0;
            wdata        <= 32'd0;
            out_of_range <= 1'b0;
            out_q        <= 32'd0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    if (bus.mem_enable) begin
                        op_write     <= bus.mem_write;
                        idx          <= bus.mem_address[ADDR_W+1:2];
                        wdata        <= bus.mem_in;
                        out_of_range <= addr_oor;
                        cnt          <= CNT_LOAD;
                        ready_q      <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        if (!op_write) begin
                            out_q <= out_of_range ? 32'd0 : ram[idx];
                        end
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        error_q <= out_of_range;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_out   = out_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_done  = done_q;
    assign bus.mem_error = error_q;

endmodule

// File: tb/tb_sysmem_responder.sv
// ---------------------------------------------------------------------------
// tb_sysmem_responder
// Drives two responders (LATENCY=2 and LATENCY=3, both ADDR_W=10) with
// directed requests. Expected responses are queued when a request is issued
// and compared by independent monitors whenever a DUT pulses mem_done.
// ---------------------------------------------------------------------------
module tb_sysmem_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic  clock;
    logic  reset;
    int    checks;
    int    errors;
    resp_t sb2[$];
    resp_t sb3[$];

    sysmem_responder_if bus2 ();
    sysmem_responder_if bus3 ();

    sysmem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    sysmem_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case anything stalls forever.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    // Single comparison point shared by the stimulus and both monitors.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor for the LATENCY=2 responder.
    always @(negedge clock) begin
        resp_t e;
        if (bus2.mem_done === 1'b1) begin
            if (sb2.size() == 0) begin
                check_output("dut2_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb2.pop_front();
                check_output("dut2_mem_out", bus2.mem_out, e.data);
                check_output("dut2_mem_error", {31'd0, bus2.mem_error}, {31'd0, e.err});
            end
        end
    end

    // Scoreboard monitor for the LATENCY=3 responder.
    always @(negedge clock) begin
        resp_t e;
        if (bus3.mem_done === 1'b1) begin
            if (sb3.size() == 0) begin
                check_output("dut3_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb3.pop_front();
                check_output("dut3_mem_out", bus3.mem_out, e.data);
                check_output("dut3_mem_error", {31'd0, bus3.mem_error}, {31'd0, e.err});
            end
        end
    end

    // One access on the LATENCY=2 port. op = {mem_write, mem_read}. When
    // scramble is set, the inputs are altered and the strobe held during the
    // busy cycles to show that only the accepted values are used.
    task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [31:0] exp_out,
                                  input logic exp_err, input bit scramble);
        @(negedge clock);
        check_output("ready_before_request", {31'd0, bus2.mem_ready}, 32'd1);
        bus2.mem_enable  = 1'b1;
        bus2.mem_write   = op[1];
        bus2.mem_read    = op[0];
        bus2.mem_address = addr;
        bus2.mem_in      = data;
        sb2.push_back('{data: exp_out, err: exp_err});
        @(posedge clock);
        #1;
        if (scramble) begin
            bus2.mem_address = addr ^ 32'h70;
            bus2.mem_in      = ~data;
            bus2.mem_write   = ~op[1];
            bus2.mem_read    = ~op[0];
        end else begin
            bus2.mem_enable = 1'b0;
            bus2.mem_write  = 1'b0;
            bus2.mem_read   = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check_output("ready_low_busy", {31'd0, bus2.mem_ready}, 32'd0);
            check_output("done_low_busy", {31'd0, bus2.mem_done}, 32'd0);
        end
        @(negedge clock);
        check_output("ready_high_done", {31'd0, bus2.mem_ready}, 32'd1);
        check_output("done_pulse", {31'd0, bus2.mem_done}, 32'd1);
        bus2.mem_enable = 1'b0;
        bus2.mem_write  = 1'b0;
        bus2.mem_read   = 1'b0;
    endtask

    // Main directed sequence.
    initial begin
        bit found;
        int low_count;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus2.mem_enable = 1'b0; bus2.mem_read = 1'b0; bus2.mem_write = 1'b0;
        bus2.mem_address = 32'd0; bus2.mem_in = 32'd0;
        bus3.mem_enable = 1'b0; bus3.mem_read = 1'b0; bus3.mem_write = 1'b0;
        bus3.mem_address = 32'd0; bus3.mem_in = 32'd0;

        repeat (3) @(negedge clock);
        check_output("reset_ready", {31'd0, bus2.mem_ready}, 32'd1);
        check_output("reset_out", bus2.mem_out, 32'd0);
        check_output("reset_done", {31'd0, bus2.mem_done}, 32'd0);
        check_output("reset_error", {31'd0, bus2.mem_error}, 32'd0);
        reset = 1'b0;

        // Write then read back, plus ignored low address bits and the
        // "neither read nor write" strobe behaving as a read.
        apply_stimulus(2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        apply_stimulus(2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        apply_stimulus(2'b00, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Both strobes set: the write wins and mem_out stays put.
        apply_stimulus(2'b11, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0);

        // Out-of-range accesses: error pulse, read returns 0, write discarded.
        apply_stimulus(2'b01, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(2'b10, 32'h1000, 32'h1, 32'h0, 1'b1, 1'b0);
        apply_stimulus(2'b01, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);

        // Last in-range word and a far out-of-range address.
        apply_stimulus(2'b10, 32'hFFC, 32'h0BADF00D, 32'hA5A5A5A5, 1'b0, 1'b0);
        apply_stimulus(2'b01, 32'hFFE, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
        apply_stimulus(2'b01, 32'h80000000, 32'h0, 32'h0, 1'b1, 1'b0);

        // Preload words used by the abort and scramble cases.
        apply_stimulus(2'b10, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b0);
        apply_stimulus(2'b10, 32'h40, 32'h44444444, 32'h0, 1'b0, 1'b0);
        apply_stimulus(2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Reset one cycle into BUSY aborts a write to 0x20.
        @(negedge clock);
        bus2.mem_enable  = 1'b1;
        bus2.mem_write   = 1'b1;
        bus2.mem_read    = 1'b0;
        bus2.mem_address = 32'h20;
        bus2.mem_in      = 32'h12345678;
        @(posedge clock);
        #1;
        bus2.mem_enable = 1'b0;
        bus2.mem_write  = 1'b0;
        @(negedge clock);
        check_output("abort_busy_ready", {31'd0, bus2.mem_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check_output("abort_ready", {31'd0, bus2.mem_ready}, 32'd1);
        check_output("abort_out", bus2.mem_out, 32'd0);
        check_output("abort_done", {31'd0, bus2.mem_done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        apply_stimulus(2'b01, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b0);

        // Inputs changed while busy: the write lands at 0x30 with the
        // original data, and 0x40 keeps its earlier value.
        apply_stimulus(2'b10, 32'h30, 32'h55AA55AA, 32'h11111111, 1'b0, 1'b1);
        apply_stimulus(2'b01, 32'h30, 32'h0, 32'h55AA55AA, 1'b0, 1'b0);
        apply_stimulus(2'b01, 32'h40, 32'h0, 32'h44444444, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clock);
            check_output("idle_ready", {31'd0, bus2.mem_ready}, 32'd1);
            check_output("idle_no_done", {31'd0, bus2.mem_done}, 32'd0);
        end

        // LATENCY=3 port: preload 0x10, then hold a read strobe and check
        // the five-cycle cadence.
        @(negedge clock);
        bus3.mem_enable  = 1'b1;
        bus3.mem_write   = 1'b1;
        bus3.mem_read    = 1'b0;
        bus3.mem_address = 32'h10;
        bus3.mem_in      = 32'hCAFEF00D;
        sb3.push_back('{data: 32'h0, err: 1'b0});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (bus3.mem_done === 1'b1) found = 1'b1;
        end
        check_output("lat3_write_done_seen", {31'd0, found}, 32'd1);
        bus3.mem_write = 1'b0;
        bus3.mem_read  = 1'b1;
        repeat (3) sb3.push_back('{data: 32'hCAFEF00D, err: 1'b0});
        low_count = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            if (bus3.mem_ready === 1'b0) low_count++;
            check_output("lat3_done_cadence", {31'd0, bus3.mem_done},
                         (k % 5 == 0) ? 32'd1 : 32'd0);
            check_output("lat3_ready_cadence", {31'd0, bus3.mem_ready},
                         ((k % 5 == 0) || (k % 5 == 1)) ? 32'd1 : 32'd0);
        end
        bus3.mem_enable = 1'b0;
        bus3.mem_read   = 1'b0;
        check_output("lat3_ready_low_cycles", low_count, 32'd9);

        repeat (4) @(negedge clock);
        check_output("dut2_scoreboard_drained", sb2.size(), 32'd0);
        check_output("dut3_scoreboard_drained", sb3.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
